// File: rtl/id_decode_pkg.sv
// Shared widths, shift encodings and instruction-class constants for the
// AArch64 decode stage.
package id_decode_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int OpCodeBus   = 11;
    localparam int RegAddrBus  = 5;
    localparam int RegBus      = 64;
    localparam int NumRegs     = 32;

    localparam logic [RegAddrBus-1:0] XZR_IDX = 5'd31;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    // inst[28:24] values selecting the shifted-register operand-2 form
    localparam logic [4:0] CLASS_LOG_SHIFT    = 5'b01010;
    localparam logic [4:0] CLASS_ADDSUB_SHIFT = 5'b01011;

    localparam logic [OpCodeBus-1:0] OP_ORR64 = 11'b10101010000;

endpackage

// File: rtl/id_regfile.sv
// 32x64 general-purpose register file with two combinational read ports.
// Entry 31 is XZR and always reads zero; reset loads Xi = i.
module id_regfile
    import id_decode_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [RegAddrBus-1:0] raddr1_i,
    input  logic [RegAddrBus-1:0] raddr2_i,
    output logic [RegBus-1:0]     rdata1_o,
    output logic [RegBus-1:0]     rdata2_o
);

    // XZR needs no storage, so only X0..X30 are held
    logic [RegBus-1:0] regs_q [NumRegs-1];

    // NOTE: this storage is reset on purpose: the reset value Xi = i is
    // architecturally visible, unlike an ordinary RAM which is left unreset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumRegs - 1; i++) begin
                regs_q[i] <= RegBus'(i);
            end
        end else begin
            for (int i = 0; i < NumRegs - 1; i++) begin
                regs_q[i] <= regs_q[i];
            end
        end
    end

    assign rdata1_o = (raddr1_i == XZR_IDX) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == XZR_IDX) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: field extraction, operand read, optional
// operand-2 shifter (enabled by macro ID_SHIFT_EN) and registered outputs.
module id_decode_stage
    import id_decode_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [InstAddrBus-1:0] id_pc_i,
    input  logic [InstBus-1:0]     id_inst_i,
    output logic [OpCodeBus-1:0]   ex_opcode_o,
    output logic [RegAddrBus-1:0]  ex_waddr_o,
    output logic [RegBus-1:0]      ex_reg1_o,
    output logic [RegBus-1:0]      ex_reg2_o
);

    logic [OpCodeBus-1:0]  opcode_d;
    logic [RegAddrBus-1:0] waddr_d;
    logic [RegAddrBus-1:0] rn_addr;
    logic [RegAddrBus-1:0] rm_addr;
    logic [RegBus-1:0]     rn_data;
    logic [RegBus-1:0]     rm_data;
    logic [RegBus-1:0]     reg2_d;

    logic [OpCodeBus-1:0]  opcode_q;
    logic [RegAddrBus-1:0] waddr_q;
    logic [RegBus-1:0]     reg1_q;
    logic [RegBus-1:0]     reg2_q;

    assign opcode_d = id_inst_i[31:21];
    assign waddr_d  = id_inst_i[4:0];
    assign rn_addr  = id_inst_i[9:5];
    assign rm_addr  = id_inst_i[20:16];

    // PC is reserved for branch decode and currently drives nothing
    logic unused_pc;
    assign unused_pc = ^id_pc_i;

    id_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .raddr1_i (rn_addr),
        .raddr2_i (rm_addr),
        .rdata1_o (rn_data),
        .rdata2_o (rm_data)
    );

`ifdef ID_SHIFT_EN
    shift_e     sh_type;
    logic [5:0] sh_amt;
    logic [4:0] inst_class;

    assign sh_type    = shift_e'(id_inst_i[23:22]);
    assign sh_amt     = id_inst_i[15:10];
    assign inst_class = id_inst_i[28:24];

    // NOTE: every always_comb output is given a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        reg2_d = rm_data;
        if (inst_class == CLASS_LOG_SHIFT || inst_class == CLASS_ADDSUB_SHIFT) begin
            case (sh_type)
                SHIFT_LSL: reg2_d = rm_data << sh_amt;
                SHIFT_LSR: reg2_d = rm_data >> sh_amt;
                SHIFT_ASR: reg2_d = $signed(rm_data) >>> sh_amt;
                SHIFT_ROR: begin
                    // ROR is reserved for add/sub, which keeps Rm unshifted
                    if (inst_class == CLASS_LOG_SHIFT) begin
                        reg2_d = (rm_data >> sh_amt) | (rm_data << (7'd64 - {1'b0, sh_amt}));
                    end
                end
            endcase
        end
    end
`else
    logic unused_shift;
    assign unused_shift = ^{id_inst_i[23:22], id_inst_i[15:10]};
    assign reg2_d       = rm_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opcode_q <= '0;
            waddr_q  <= '0;
            reg1_q   <= '0;
            reg2_q   <= '0;
        end else begin
            opcode_q <= opcode_d;
            waddr_q  <= waddr_d;
            reg1_q   <= rn_data;
            reg2_q   <= reg2_d;
        end
    end

    assign ex_opcode_o = opcode_q;
    assign ex_waddr_o  = waddr_q;
    assign ex_reg1_o   = reg1_q;
    assign ex_reg2_o   = reg2_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage against a behavioural model of the
// decode rules; expectations follow ID_SHIFT_EN the same way as the design.
module tb_id_decode_stage;
    import id_decode_pkg::*;

    typedef struct packed {
        logic [10:0] op;
        logic [4:0]  wa;
        logic [63:0] r1;
        logic [63:0] r2;
    } out_t;

    logic        clock;
    logic        reset;
    logic [31:0] id_pc_i;
    logic [31:0] id_inst_i;
    logic [10:0] ex_opcode_o;
    logic [4:0]  ex_waddr_o;
    logic [63:0] ex_reg1_o;
    logic [63:0] ex_reg2_o;
    out_t        obs;

    int n_checks = 0;
    int n_fail   = 0;

    id_decode_stage dut (
        .clock       (clock),
        .reset       (reset),
        .id_pc_i     (id_pc_i),
        .id_inst_i   (id_inst_i),
        .ex_opcode_o (ex_opcode_o),
        .ex_waddr_o  (ex_waddr_o),
        .ex_reg1_o   (ex_reg1_o),
        .ex_reg2_o   (ex_reg2_o)
    );

    assign obs = {ex_opcode_o, ex_waddr_o, ex_reg1_o, ex_reg2_o};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Register contents after reset: Xi = i, X31 reads zero
    function automatic logic [63:0] reg_val(input logic [4:0] idx);
        return (idx == 5'd31) ? 64'd0 : {59'd0, idx};
    endfunction

    // Decode rules applied one shift step at a time
    function automatic out_t model(input logic [31:0] inst);
        out_t        e;
        logic [63:0] v;
        logic [4:0]  cls;
        logic [1:0]  t;
        int          amt;
        e.op = inst[31:21];
        e.wa = inst[4:0];
        e.r1 = reg_val(inst[9:5]);
        v    = reg_val(inst[20:16]);
        cls  = inst[28:24];
        t    = inst[23:22];
        amt  = int'(inst[15:10]);
`ifdef ID_SHIFT_EN
        if (cls == 5'b01010 || (cls == 5'b01011 && t != 2'b11)) begin
            for (int k = 0; k < amt; k++) begin
                case (t)
                    2'b00: v = v * 64'd2;
                    2'b01: v = v / 64'd2;
                    2'b10: v = {v[63], v[63:1]};
                    default: v = {v[0], v[63:1]};
                endcase
            end
        end
`endif
        e.r2 = v;
        return e;
    endfunction

    task automatic step(input logic [31:0] inst);
        @(negedge clock);
        id_inst_i = inst;
        id_pc_i   = $urandom;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        out_t zero = '0;
        reset     = 1'b0;
        id_pc_i   = $urandom;
        id_inst_i = $urandom;
        #3;
        n_checks++;
        if (obs !== zero) begin
            n_fail++;
            $display("FAIL reset_async: got %h required %h", obs, zero);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (obs !== zero) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required %h", obs, zero);
        end
        @(negedge clock);
        #2;
        reset     = 1'b1;
        id_inst_i = 32'd0;
        @(posedge clock);
        #1;
        n_checks++;
        if (obs !== zero) begin
            n_fail++;
            $display("FAIL reset_release_inst0: got %h required %h", obs, zero);
        end
    endtask

    task automatic test_directed();
        logic [31:0] insts [7];
        out_t        exps  [7];
        insts[0] = 32'b10101010000_00000_000000_00001_00010;
        exps[0]  = {11'h550, 5'd2, 64'd1, 64'd0};
        insts[1] = 32'b10101010000_00011_000000_00100_00101;
        exps[1]  = {11'h550, 5'd5, 64'd4, 64'd3};
        insts[2] = 32'b10101010000_00011_000010_00100_00101;
        insts[3] = 32'b10101010000_11111_000000_11111_00001;
        exps[3]  = {11'h550, 5'd1, 64'd0, 64'd0};
        // ROR #1 of X1 (logical), ROR #1 of X1 (add/sub), LSL #63 of X3
        insts[4] = {1'b1, 2'b01, 5'b01010, 2'b11, 1'b0, 5'd1, 6'd1, 5'd30, 5'd7};
        insts[5] = {1'b1, 2'b10, 5'b01011, 2'b11, 1'b0, 5'd1, 6'd1, 5'd30, 5'd7};
        insts[6] = {1'b1, 2'b01, 5'b01010, 2'b00, 1'b0, 5'd3, 6'd63, 5'd30, 5'd9};
`ifdef ID_SHIFT_EN
        exps[2]  = {11'h550, 5'd5, 64'd4, 64'd12};
        exps[4]  = {insts[4][31:21], 5'd7, 64'd30, 64'h8000_0000_0000_0000};
        exps[6]  = {insts[6][31:21], 5'd9, 64'd30, 64'h8000_0000_0000_0000};
`else
        exps[2]  = {11'h550, 5'd5, 64'd4, 64'd3};
        exps[4]  = {insts[4][31:21], 5'd7, 64'd30, 64'd1};
        exps[6]  = {insts[6][31:21], 5'd9, 64'd30, 64'd3};
`endif
        exps[5]  = {insts[5][31:21], 5'd7, 64'd30, 64'd1};
        for (int i = 0; i < 7; i++) begin
            step(insts[i]);
            n_checks++;
            if (obs !== exps[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got %h required %h", i, obs, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] inst;
        out_t        exp;
        for (int i = 0; i < 300; i++) begin
            inst = $urandom;
            if (i % 2 == 0) begin
                inst[28:24] = ($urandom_range(0, 1) == 0) ? 5'b01010 : 5'b01011;
            end
            exp = model(inst);
            step(inst);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random_%0d inst %h: got %h required %h", i, inst, obs, exp);
            end
        end
    endtask

    task automatic test_pc_ignored();
        logic [31:0] inst = 32'b10101010000_00011_000000_00100_00101;
        out_t        exp  = {11'h550, 5'd5, 64'd4, 64'd3};
        for (int i = 0; i < 4; i++) begin
            step(inst);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pc_ignored_%0d pc %h: got %h required %h", i, id_pc_i, obs, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] inst = 32'b10101010000_00011_000000_00100_00101;
        out_t        exp  = {11'h550, 5'd5, 64'd4, 64'd3};
        out_t        zero = '0;
        step(inst);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_reset_before: got %h required %h", obs, exp);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== zero) begin
            n_fail++;
            $display("FAIL mid_reset_async_clear: got %h required %h", obs, zero);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (obs !== zero) begin
            n_fail++;
            $display("FAIL mid_reset_hold: got %h required %h", obs, zero);
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_reset_after_release: got %h required %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_pc_ignored();
        test_mid_reset();
        test_directed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
